// File: rtl/danmaku_overlay_mixer.sv
// danmaku_overlay_mixer
//   Blends the danmaku overlay pixel stream onto live video in the pixel
//   clock domain. Each active video pixel pulls one overlay word. The word's
//   low byte selects opaque, shadow, outline or transparent rendering.
//   Timing and RGB leave exactly two cycles after they arrive.
//   A pixel served while the overlay FIFO is empty is drawn transparent.
//   It is then recorded as debt. The debt is paid back by discarding overlay
//   words during blanking, so a late FIFO cannot shear later frames.
//
// Ports:
//   clk, rst            pixel clock; synchronous active-high reset
//   enable              overlay enable (0 = pass-through, no FIFO reads)
//   vid_de/hs/vs_in     video timing in
//   vid_rgb_in          background pixel {R,G,B}
//   ovl_pixel           overlay word {R,G,B,code}, valid the cycle after ovl_req
//   ovl_empty           overlay FIFO empty
//   ovl_req             overlay FIFO read strobe (combinational)
//   vid_de/hs/vs_out    timing delayed by 2 cycles
//   vid_rgb_out         blended pixel, delayed by 2 cycles
//   underflow_cnt       saturating count of active pixels served without data
//   debt                saturating count of overlay words still to discard
module danmaku_overlay_mixer #(
    parameter int DEBT_W = 20,
    parameter int UFL_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              vid_de_in,
    input  logic              vid_hs_in,
    input  logic              vid_vs_in,
    input  logic [23:0]       vid_rgb_in,
    input  logic [31:0]       ovl_pixel,
    input  logic              ovl_empty,
    output logic              ovl_req,
    output logic              vid_de_out,
    output logic              vid_hs_out,
    output logic              vid_vs_out,
    output logic [23:0]       vid_rgb_out,
    output logic [UFL_W-1:0]  underflow_cnt,
    output logic [DEBT_W-1:0] debt
);

    localparam logic [7:0] CODE_OPAQUE  = 8'hFF;
    localparam logic [7:0] CODE_SHADOW  = 8'h01;
    localparam logic [7:0] CODE_OUTLINE = 8'h02;

    logic              take;
    logic              discard;
    logic              underflow;

    logic [DEBT_W-1:0] debt_q, debt_d;
    logic [UFL_W-1:0]  ufl_q,  ufl_d;

    // Stage 1: timing, background and whether this pixel consumed a word.
    logic        s1_de_q,   s1_de_d;
    logic        s1_hs_q,   s1_hs_d;
    logic        s1_vs_q,   s1_vs_d;
    logic [23:0] s1_rgb_q,  s1_rgb_d;
    logic        s1_take_q, s1_take_d;

    // Stage 2: the output registers.
    logic        s2_de_q,   s2_de_d;
    logic        s2_hs_q,   s2_hs_d;
    logic        s2_vs_q,   s2_vs_d;
    logic [23:0] s2_rgb_q,  s2_rgb_d;

    logic [7:0]  code;

    // Blanking reads are only issued while there is debt to pay down.
    always_comb begin
        ovl_req   = !rst && enable && !ovl_empty && (vid_de_in || (debt_q != '0));
        take      = ovl_req && vid_de_in;
        discard   = ovl_req && !vid_de_in;
        underflow = enable && vid_de_in && ovl_empty;
    end

    // Underflow and discard can never coincide because they need opposite
    // vid_de_in values. A discard implies that debt_q is nonzero, so the
    // decrement cannot wrap.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
        debt_d = debt_q;
        ufl_d  = ufl_q;
        if (underflow) begin
            if (debt_q != '1) debt_d = debt_q + DEBT_W'(1);
            if (ufl_q  != '1) ufl_d  = ufl_q  + UFL_W'(1);
        end else if (discard) begin
            debt_d = debt_q - DEBT_W'(1);
        end
    end

    always_comb begin
        s1_de_d   = vid_de_in;
        s1_hs_d   = vid_hs_in;
        s1_vs_d   = vid_vs_in;
        s1_rgb_d  = vid_rgb_in;
        s1_take_d = take;
    end

    // ovl_pixel is meaningful only in the cycle after a take.
    // Otherwise the pixel is forced transparent (code 0x00).
    always_comb begin
        code     = s1_take_q ? ovl_pixel[7:0] : 8'h00;
        s2_de_d  = s1_de_q;
        s2_hs_d  = s1_hs_q;
        s2_vs_d  = s1_vs_q;
        s2_rgb_d = s1_rgb_q;
        case (code)
            CODE_OPAQUE:  s2_rgb_d = ovl_pixel[31:8];
            CODE_SHADOW:  s2_rgb_d = {1'b0, s1_rgb_q[23:17],
                                      1'b0, s1_rgb_q[15:9],
                                      1'b0, s1_rgb_q[7:1]};
            CODE_OUTLINE: s2_rgb_d = 24'h000000;
            default:      s2_rgb_d = s1_rgb_q;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values regardless of statement order.
        if (rst) begin
            debt_q    <= '0;
            ufl_q     <= '0;
            s1_de_q   <= 1'b0;
            s1_hs_q   <= 1'b0;
            s1_vs_q   <= 1'b0;
            s1_rgb_q  <= '0;
            s1_take_q <= 1'b0;
            s2_de_q   <= 1'b0;
            s2_hs_q   <= 1'b0;
            s2_vs_q   <= 1'b0;
            s2_rgb_q  <= '0;
        end else begin
            debt_q    <= debt_d;
            ufl_q     <= ufl_d;
            s1_de_q   <= s1_de_d;
            s1_hs_q   <= s1_hs_d;
            s1_vs_q   <= s1_vs_d;
            s1_rgb_q  <= s1_rgb_d;
            s1_take_q <= s1_take_d;
            s2_de_q   <= s2_de_d;
            s2_hs_q   <= s2_hs_d;
            s2_vs_q   <= s2_vs_d;
            s2_rgb_q  <= s2_rgb_d;
        end
    end

    assign vid_de_out    = s2_de_q;
    assign vid_hs_out    = s2_hs_q;
    assign vid_vs_out    = s2_vs_q;
    assign vid_rgb_out   = s2_rgb_q;
    assign underflow_cnt = ufl_q;
    assign debt          = debt_q;

endmodule

// File: tb/tb_danmaku_overlay_mixer.sv
// tb_danmaku_overlay_mixer
//   Self-checking bench for danmaku_overlay_mixer. The overlay FIFO is a queue
//   of words. Each cycle the bench predicts, from the queue and its own
//   debt/underflow bookkeeping, what the pixel should show and what should
//   appear two cycles later. Small counter widths keep the saturation cases
//   short.
module tb_danmaku_overlay_mixer;

    localparam int DEBT_W = 4;
    localparam int UFL_W  = 6;
    localparam int DMAX   = (1 << DEBT_W) - 1;
    localparam int UMAX   = (1 << UFL_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic              de, hs, vs;
    logic [23:0]       bg;
    logic [31:0]       ovl_pixel;
    logic              ovl_empty;
    logic              ovl_req;
    logic              vid_de_out, vid_hs_out, vid_vs_out;
    logic [23:0]       vid_rgb_out;
    logic [UFL_W-1:0]  underflow_cnt;
    logic [DEBT_W-1:0] debt;

    danmaku_overlay_mixer #(.DEBT_W(DEBT_W), .UFL_W(UFL_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .vid_de_in     (de),
        .vid_hs_in     (hs),
        .vid_vs_in     (vs),
        .vid_rgb_in    (bg),
        .ovl_pixel     (ovl_pixel),
        .ovl_empty     (ovl_empty),
        .ovl_req       (ovl_req),
        .vid_de_out    (vid_de_out),
        .vid_hs_out    (vid_hs_out),
        .vid_vs_out    (vid_vs_out),
        .vid_rgb_out   (vid_rgb_out),
        .underflow_cnt (underflow_cnt),
        .debt          (debt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic [23:0] rgb;
    } vout_t;

    typedef struct {
        logic [23:0] bg;
        logic [31:0] word;
        logic [23:0] exp_rgb;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] fifo[$];
    vout_t       exp_q[$];
    int          debt_m  = 0;
    int          ufl_m   = 0;
    logic        force_empty;
    logic        last_req;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] blend(input logic [23:0] b, input logic [31:0] w);
        case (w[7:0])
            8'hFF:   return w[31:8];
            8'h01:   return {b[23:16] >> 1, b[15:8] >> 1, b[7:0] >> 1};
            8'h02:   return 24'h000000;
            default: return b;
        endcase
    endfunction

    // One pixel clock. The caller has already driven this cycle's inputs.
    // On return the time is just after the edge, and the next inputs may be driven.
    task automatic tick();
        vout_t e;
        bit    req_m, take_m, disc_m, ufl_ev;
        ovl_empty = force_empty || (fifo.size() == 0);
        @(negedge clk);
        req_m  = !rst && enable && !ovl_empty && (de || debt_m != 0);
        take_m = req_m && de;
        disc_m = req_m && !de;
        ufl_ev = enable && de && ovl_empty;
        check("ovl_req", ovl_req, req_m);
        last_req = ovl_req;
        e.de  = de;
        e.hs  = hs;
        e.vs  = vs;
        e.rgb = take_m ? blend(bg, fifo[0]) : bg;
        @(posedge clk);
        #1;
        if (rst) begin
            // Reset flushes both pipeline stages, so the next two outputs are zero.
            debt_m = 0;
            ufl_m  = 0;
            e      = '0;
            if (exp_q.size() > 0) exp_q[exp_q.size()-1] = '0;
        end else begin
            if (req_m) ovl_pixel = fifo.pop_front();
            if (ufl_ev) begin
                if (debt_m < DMAX) debt_m++;
                if (ufl_m  < UMAX) ufl_m++;
            end else if (disc_m) begin
                debt_m--;
            end
        end
        exp_q.push_back(e);
        if (exp_q.size() > 2) void'(exp_q.pop_front());
        if (exp_q.size() == 2) begin
            check("de_out",  vid_de_out,  exp_q[0].de);
            check("hs_out",  vid_hs_out,  exp_q[0].hs);
            check("vs_out",  vid_vs_out,  exp_q[0].vs);
            check("rgb_out", vid_rgb_out, exp_q[0].rgb);
        end
        check("debt",          debt,          debt_m);
        check("underflow_cnt", underflow_cnt, ufl_m);
    endtask

    task automatic reset_pulse(input int cycles);
        rst = 1'b1;
        for (int i = 0; i < cycles; i++) tick();
        rst = 1'b0;
    endtask

    initial begin
        vec_t        tbl[4];
        logic [31:0] w[11];
        logic [UFL_W-1:0]  ufl_save;
        logic [DEBT_W-1:0] debt_save;
        int          nreq;

        tbl[0] = '{24'h808080, 32'hFF0000_FF, 24'hFF0000};
        tbl[1] = '{24'h808080, 32'h123456_00, 24'h808080};
        tbl[2] = '{24'h808080, 32'hABCDEF_01, 24'h404040};
        tbl[3] = '{24'h808080, 32'h55AA55_02, 24'h000000};

        rst = 1'b1; enable = 1'b0; de = 1'b0; hs = 1'b0; vs = 1'b0;
        bg = '0; force_empty = 1'b0; ovl_empty = 1'b1;
        // Garbage with an opaque code: must never reach the output without a take.
        ovl_pixel = 32'hDEADBE_FF;

        // 1: four codes over a grey background.
        reset_pulse(3);
        enable = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 4; i++) fifo.push_back(tbl[i].word);
        for (int i = 0; i < 6; i++) begin
            de = (i < 4);
            bg = (i < 4) ? tbl[i].bg : 24'h0;
            tick();
            check("t1_req", last_req, (i < 4));
            if (i >= 1 && i <= 4) check("t1_rgb", vid_rgb_out, tbl[i-1].exp_rgb);
        end

        // 2: three underflows mid-line, then repaid in hblank.
        reset_pulse(1);
        for (int k = 0; k < 11; k++) begin
            w[k] = {8'(k * 16 + 1), 8'h22, 8'h33, 8'hFF};
            fifo.push_back(w[k]);
        end
        bg = 24'h808080;
        for (int i = 0; i < 7; i++) begin
            de = 1'b1;
            force_empty = (i >= 2 && i <= 4);
            tick();
        end
        force_empty = 1'b0;
        check("t2_ufl",  underflow_cnt, 3);
        check("t2_debt", debt, 3);
        de = 1'b0;
        nreq = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            nreq += int'(last_req);
        end
        check("t2_discards", nreq, 3);
        check("t2_debt0",    debt, 0);
        de = 1'b1; bg = 24'h0F0F0F;
        tick();
        de = 1'b0;
        tick();
        check("t2_realign", vid_rgb_out, w[7][31:8]);

        // 3: overlay disabled across a line with data waiting.
        enable = 1'b0;
        ufl_save = underflow_cnt;
        debt_save = debt;
        nreq = 0;
        for (int i = 0; i < 10; i++) begin
            de = (i >= 1 && i <= 8);
            hs = (i == 9);
            bg = 24'($urandom);
            tick();
            nreq += int'(last_req);
        end
        check("t3_no_req", nreq, 0);
        check("t3_ufl",    underflow_cnt, ufl_save);
        check("t3_debt",   debt, debt_save);
        hs = 1'b0;

        // 4: reset mid-line with debt 5 and a take in flight.
        enable = 1'b1; de = 1'b1;
        force_empty = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("t4_debt5", debt, 5);
        force_empty = 1'b0;
        fifo.push_back(32'h00FF00_FF);
        bg = 24'h112233;
        tick();
        rst = 1'b1;
        tick();
        check("t4_req_rst", last_req, 0);
        check("t4_rgb0",    vid_rgb_out, 0);
        check("t4_de0",     vid_de_out, 0);
        check("t4_debt0",   debt, 0);
        check("t4_ufl0",    underflow_cnt, 0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) fifo.push_back({24'($urandom), 8'hFF});
        for (int i = 0; i < 5; i++) begin
            bg = 24'($urandom);
            tick();
        end

        // 5: saturation of both counters.
        force_empty = 1'b1;
        for (int i = 0; i < DMAX + 5; i++) tick();
        check("t5_debt_max", debt, DMAX);
        check("t5_ufl",      underflow_cnt, DMAX + 5);
        tick();
        check("t5_debt_hold", debt, DMAX);
        check("t5_ufl_inc",   underflow_cnt, DMAX + 6);
        for (int i = 0; i < UMAX; i++) tick();
        check("t5_ufl_max", underflow_cnt, UMAX);
        force_empty = 1'b0;

        // 6: sync toggling in blanking with no debt.
        reset_pulse(1);
        de = 1'b0;
        nreq = 0;
        for (int i = 0; i < 10; i++) begin
            hs = 1'($urandom);
            vs = 1'($urandom);
            tick();
            nreq += int'(last_req);
        end
        check("t6_no_req", nreq, 0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rst         = ($urandom_range(0, 59) == 0);
            enable      = ($urandom_range(0, 7) != 0);
            de          = ($urandom_range(0, 2) != 0);
            hs          = 1'($urandom);
            vs          = 1'($urandom);
            bg          = 24'($urandom);
            force_empty = ($urandom_range(0, 4) == 0);
            if (fifo.size() < 4 && $urandom_range(0, 1) == 1) begin
                logic [7:0] c;
                case ($urandom_range(0, 4))
                    0: c = 8'hFF;
                    1: c = 8'h01;
                    2: c = 8'h02;
                    3: c = 8'h00;
                    default: c = 8'($urandom);
                endcase
                fifo.push_back({24'($urandom), c});
            end
            tick();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/danmaku_overlay_mixer.md
Name: danmaku_overlay_mixer

Overview:
- Consumes the 32-bit overlay pixel stream from the danmaku pixel adapter (sink side) and blends it onto the live video stream in the sink clock domain.
- Pulls one overlay pixel per active video pixel and applies the opaque, shadow, outline and transparent codes.
- Re-emits video timing and RGB with a fixed 2-cycle latency.
- Tracks FIFO underflow and realigns the overlay stream during blanking so a late FIFO never shears later frames.

Parameters:
DEBT_W, 20, width of the owed-pixel (debt) counter; saturates at all-ones
UFL_W, 16, width of the underflow statistics counter; saturates at all-ones

Ports:
clk  input  1  pixel clock, same as the adapter's clk_sink
rst  input  1  synchronous reset, active-high
enable  input  1  overlay enable; 0 = pure pass-through, no FIFO reads
vid_de_in  input  1  active-video qualifier
vid_hs_in  input  1  hsync, passed through
vid_vs_in  input  1  vsync, passed through
vid_rgb_in  input  24  background {R[23:16],G[15:8],B[7:0]}
ovl_pixel  input  32  adapter pixel_sink {R,G,B,code}; updates the cycle after ovl_req
ovl_empty  input  1  adapter empty_sink
ovl_req  output  1  adapter req_sink; read strobe
vid_de_out  output  1  delayed vid_de_in
vid_hs_out  output  1  delayed vid_hs_in
vid_vs_out  output  1  delayed vid_vs_in
vid_rgb_out  output  24  blended RGB
underflow_cnt  output  UFL_W  number of active pixels served without overlay data
debt  output  DEBT_W  overlay pixels owed (to be discarded)

Behaviour:
- Single clock domain: clk. Reset: rst, synchronous, active-high.
- While rst=1:
  - ovl_req=0.
  - All registered outputs, underflow_cnt, debt and pipeline flags are cleared to 0.
  - rst mid-frame takes effect at the next edge; output resumes pass-through 2 cycles after rst falls.
- ovl_req is combinational: ovl_req = !rst & enable & !ovl_empty & (vid_de_in | (debt != 0)).
- take = ovl_req & vid_de_in. This is a real read consumed by the current pixel.
- discard = ovl_req & !vid_de_in. This is a blanking read used to pay down debt.
- underflow = enable & vid_de_in & ovl_empty. The pixel is treated as transparent. On the next edge:
  - debt increments (saturating).
  - underflow_cnt increments (saturating).
- discard decrements debt by 1.
- underflow and discard are mutually exclusive by construction (opposite vid_de_in).
- Pipeline stage 1 (registered at edge after cycle t): de, hs, vs, rgb and the take flag. The adapter's ovl_pixel becomes valid in this same cycle t+1.
- Stage 2 (registered at edge after t+1): blend, using ovl_pixel as the overlay when the stage-1 take flag is set, and code 0x00 otherwise.
- All four outputs appear at t+2. Latency is exactly 2 cycles for de/hs/vs/rgb, independent of enable.
- Blend by code = ovl_pixel[7:0]:
  - 0xFF (opaque): out = ovl_pixel[31:8].
  - 0x01 (shadow): each channel = background channel >> 1.
  - 0x02 (outline): out = 24'h000000.
  - any other value, incl. 0x00: out = background.
- enable=0:
  - No reads and no counter changes; debt is held.
  - Output equals input, delayed 2 cycles.
  - A pixel whose take was registered before enable fell still blends normally.
- ovl_pixel holds its value between reads; the mixer never uses it unless take was registered.
- Debt at saturation: further underflows keep debt at max; underflow_cnt still counts until it too saturates.
- Debt while vid_de_in=1 is never paid; debt is serviced only in blanking, one pixel per cycle while !ovl_empty.

Test Plan:
1. Reset, then enable=1 with FIFO pre-loaded and codes {0xFF,RGB=FF0000}, 0x00, 0x01, 0x02 on 4 active pixels over background 808080 -> vid_rgb_out FF0000, 808080, 404040, 000000, each exactly 2 cycles after its input; ovl_req high for exactly those 4 de cycles.
2. ovl_empty=1 for 3 active pixels mid-line -> those outputs equal background, underflow_cnt=3, debt=3. In the following hblank with FIFO non-empty -> exactly 3 discard reqs, debt=0, and the next line's first pixel uses the correct overlay word.
3. enable=0 across a full line with FIFO non-empty -> ovl_req never asserts, output = input delayed by 2, counters unchanged.
4. Assert rst for 1 cycle mid-line with debt=5 and a take in flight -> the next cycle's outputs are 0, debt=0, underflow_cnt=0, ovl_req=0; pass-through restarts cleanly after rst falls.
5. Force debt to all-ones and apply another underflow -> debt stays at max, underflow_cnt increments. Force underflow_cnt to 16'hFFFF -> it holds.
6. hs/vs toggling with de=0 and debt=0 -> no reads; hs/vs/de out match input delayed by exactly 2 cycles.
